// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// The MSB mask helper lets any instance width derive its starting trial bit.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 13;
  localparam int MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] msb_mask(input int w);
    return MAX_WIDTH'(1) << (w - 1);
  endfunction

  localparam logic [DEF_WIDTH-1:0] DEF_MSB_MASK =
    DEF_WIDTH'(msb_mask(DEF_WIDTH));

endpackage

// File: rtl/sar_search_controller_if.sv
// Controller-to-environment bundle: start request, comparator loop and result.
// master is the controller side; slave is the comparator/requester side.
interface sar_search_controller_if
  import sar_search_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_WIDTH
);

  logic                  start_i;
  logic                  cmp_ge_i;
  logic [DATA_WIDTH-1:0] trial_o;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    input  start_i,
    input  cmp_ge_i,
    output trial_o,
    output busy_o,
    output done_o,
    output result_o
  );

  modport slave (
    output start_i,
    output cmp_ge_i,
    input  trial_o,
    input  busy_o,
    input  done_o,
    input  result_o
  );

endinterface

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation search, one bit resolved per cycle.
// trial_o is a register so the comparator input never glitches.
module sar_search_controller
  import sar_search_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_WIDTH
) (
  input logic                     clk_i,
  input logic                     rst_i,
  sar_search_controller_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] MSB =
    DATA_WIDTH'(msb_mask(DATA_WIDTH));

  state_e                state;
  state_e                state_n;
  logic [DATA_WIDTH-1:0] code;
  logic [DATA_WIDTH-1:0] code_n;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] mask_n;
  logic [DATA_WIDTH-1:0] trial;
  logic [DATA_WIDTH-1:0] trial_n;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] result_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      code   <= '0;
      mask   <= '0;
      trial  <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      code   <= code_n;
      mask   <= mask_n;
      trial  <= trial_n;
      result <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    code_n   = code;
    mask_n   = mask;
    trial_n  = trial;
    result_n = result;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_n = TRIAL;
          code_n  = '0;
          mask_n  = MSB;
          trial_n = MSB;
        end else begin
          state_n = IDLE;
          trial_n = '0;
        end
      end
      TRIAL: begin
        code_n  = bus.cmp_ge_i ? (code | mask) : code;
        mask_n  = mask >> 1;
        trial_n = code_n | mask_n;
        // mask[0] marks the LSB trial: latch the answer and park trial at 0
        if (mask[0]) begin
          state_n  = DONE;
          result_n = code_n;
          trial_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        trial_n = '0;
      end
    endcase
  end

  assign bus.trial_o  = trial;
  assign bus.busy_o   = (state == TRIAL);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result;

endmodule

// File: tb/tb_sar_search_controller.sv
// Closed-loop bench: ideal comparator, scoreboard of expected results,
// and a cycle model of busy/done/trial derived from the search rules.
module tb_sar_search_controller;
  import sar_search_pkg::*;

  localparam int WA = 13;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_search_controller_if #(.DATA_WIDTH(WA)) ifa ();
  sar_search_controller_if #(.DATA_WIDTH(WB)) ifb ();

  sar_search_controller #(.DATA_WIDTH(WA)) dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifa.master)
  );

  sar_search_controller #(.DATA_WIDTH(WB)) dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifb.master)
  );

  int   tgt[2] = '{0, 0};
  logic st[2]  = '{1'b0, 1'b0};

  assign ifa.start_i  = st[0];
  assign ifb.start_i  = st[1];
  assign ifa.cmp_ge_i = (tgt[0] >= int'(ifa.trial_o));
  assign ifb.cmp_ge_i = (tgt[1] >= int'(ifb.trial_o));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  int m_start[2]   = '{-1, -1};
  int m_next_ok[2] = '{0, 0};
  int m_tgt[2]     = '{0, 0};
  int m_res[2]     = '{0, 0};
  int exp_q0[$];
  int exp_q1[$];

  int seq[13] = '{4096, 2048, 1024, 1536, 1280, 1152, 1216,
                  1248, 1232, 1240, 1236, 1234, 1235};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int dw_of(int k);
    return (k != 0) ? WB : WA;
  endfunction

  task automatic model_edge(int k, logic s);
    int dw;
    dw = dw_of(k);
    if (rst) begin
      m_start[k]   = -1;
      m_next_ok[k] = cyc + 1;
      m_res[k]     = 0;
      if (k == 0) exp_q0.delete();
      else exp_q1.delete();
    end else begin
      if (m_start[k] >= 0 && cyc == m_start[k] + dw)
        m_res[k] = m_tgt[k];
      if (s && cyc >= m_next_ok[k]) begin
        m_start[k]   = cyc;
        m_next_ok[k] = cyc + dw + 1;
        m_tgt[k]     = tgt[k];
        if (k == 0) exp_q0.push_back(tgt[k]);
        else exp_q1.push_back(tgt[k]);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_edge(0, st[0]);
    model_edge(1, st[1]);
  end

  task automatic mon(int k, logic [31:0] tr, logic bz, logic dn,
                     logic [31:0] rs);
    int dw;
    int s;
    int b;
    int low;
    int et;
    bit eb;
    bit ed;
    int e;
    string p;
    dw  = dw_of(k);
    s   = m_start[k];
    p   = (k != 0) ? "w4" : "w13";
    eb  = (s >= 0) && (cyc >= s) && (cyc < s + dw);
    ed  = (s >= 0) && (cyc == s + dw);
    et  = 0;
    if (eb) begin
      b   = dw - 1 - (cyc - s);
      low = (1 << (b + 1)) - 1;
      et  = (m_tgt[k] & ~low) | (1 << b);
    end
    chk({p, " busy"}, 32'(bz), 32'(eb));
    chk({p, " done"}, 32'(dn), 32'(ed));
    chk({p, " trial"}, tr, et);
    chk({p, " result hold"}, rs, m_res[k]);
    if (dn === 1'b1) begin
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard: done with result %0d, none expected",
                 p, rs);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk({p, " scoreboard result"}, rs, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, 32'(ifa.trial_o), ifa.busy_o, ifa.done_o, 32'(ifa.result_o));
      mon(1, 32'(ifb.trial_o), ifb.busy_o, ifb.done_o, 32'(ifb.result_o));
    end
  end

  task automatic run_one(int k, int t);
    tgt[k] = t;
    st[k]  = 1'b1;
    @(negedge clk);
    st[k]  = 1'b0;
    repeat (dw_of(k) + 1) @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d1;
    int d2;
    d1 = 0;
    d2 = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset trial", 32'(ifa.trial_o), 0);
    chk("reset busy", 32'(ifa.busy_o), 0);
    chk("reset done", 32'(ifa.done_o), 0);
    chk("reset result", 32'(ifa.result_o), 0);
    mon_en = 1;
    rst = 1'b0;
    @(negedge clk);

    tgt[0] = 1234;
    st[0]  = 1'b1;
    @(negedge clk);
    st[0]  = 1'b0;
    for (int i = 0; i < 13; i++) begin
      chk("1234 trial seq", 32'(ifa.trial_o), seq[i]);
      chk("1234 busy", 32'(ifa.busy_o), 1);
      @(negedge clk);
    end
    chk("1234 done", 32'(ifa.done_o), 1);
    chk("1234 result", 32'(ifa.result_o), 1234);
    @(negedge clk);

    run_one(0, 0);
    run_one(0, 8191);

    tgt[0] = 4096;
    st[0]  = 1'b1;
    @(negedge clk);
    st[0]  = 1'b0;
    repeat (4) @(negedge clk);
    st[0]  = 1'b1;
    @(negedge clk);
    st[0]  = 1'b0;
    repeat (10) @(negedge clk);

    tgt[0] = 100;
    st[0]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.done_o === 1'b1) break;
    end
    d1 = cyc;
    tgt[0] = 777;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.done_o === 1'b1) break;
    end
    d2 = cyc;
    st[0] = 1'b0;
    chk("back-to-back period", d2 - d1, 14);
    chk("back-to-back result", 32'(ifa.result_o), 777);
    repeat (3) @(negedge clk);

    tgt[0] = 5000;
    st[0]  = 1'b1;
    @(negedge clk);
    st[0]  = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset trial", 32'(ifa.trial_o), 0);
    chk("midreset busy", 32'(ifa.busy_o), 0);
    chk("midreset done", 32'(ifa.done_o), 0);
    chk("midreset result", 32'(ifa.result_o), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    run_one(0, 5000);

    for (int i = 0; i < 1000; i++)
      run_one(0, int'($urandom_range(0, 8191)));

    for (int t = 0; t < 16; t++)
      run_one(1, t);

    repeat (3) @(negedge clk);
    chk("w13 pending results", exp_q0.size(), 0);
    chk("w4 pending results", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Successive-approximation controller on the driving side of an unsigned greater-or-equal comparator.
- Presents trial codes on trial_o to an external combinational comparator (A = target, B = trial_o) and reads back cmp_ge_i.
- Resolves one bit per cycle, MSB first, to the largest code not exceeding the target.
- Used for threshold search, digital SAR conversion and calibration loops.

Parameters:
DATA_WIDTH, 13, width of trial and result codes (>= 2)

Ports:
clk_i  input  1  single clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request a new search; sampled only in IDLE or DONE
cmp_ge_i  input  1  comparator result for current trial_o (1 = target >= trial_o), combinational from trial_o
trial_o  output  DATA_WIDTH  trial code driven to comparator B input
busy_o  output  1  high while a search is in progress
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  DATA_WIDTH  resolved code, held until next done_o

Behaviour:
- Reset (rst_i high at edge): state IDLE, trial_o=0, busy_o=0, done_o=0, result_o=0, internal code=0, mask=0. Reset wins over all other inputs, including mid-search; the partial result is discarded and result_o returns to 0.
- States: IDLE, TRIAL, DONE (enum in package).
- IDLE: trial_o=0, busy_o=0. If start_i=1 at edge T: code<=0, mask<=1<<(DATA_WIDTH-1), bit index<=DATA_WIDTH-1, go to TRIAL.
- TRIAL, cycles T+1 .. T+DATA_WIDTH:
  - trial_o = code | mask (registered-equivalent, glitch-free relative to clk_i); busy_o=1.
  - At each edge: if cmp_ge_i=1, code<=code|mask; else code unchanged. mask<=mask>>1.
  - After the LSB trial (mask was 1): result_o<=final code, go to DONE.
- DONE, cycle T+DATA_WIDTH+1: done_o=1, busy_o=0, trial_o=0. Next state is IDLE, or TRIAL if start_i=1 (back-to-back accepted, same init as IDLE).
- Latency: start to done_o is exactly DATA_WIDTH+1 cycles. Throughput is one search per DATA_WIDTH+1 cycles.
- start_i during TRIAL is ignored, not queued.
- cmp_ge_i is ignored outside TRIAL.
- Result property with an ideal comparator: result_o = target, for every target in 0 .. 2^DATA_WIDTH-1.
  - Target 0: every trial fails, result 0.
  - Target all-ones: every trial passes.
- Arithmetic is pure bit-set/shift, no adders. mask is one-hot or zero; one-hot is guaranteed in TRIAL.
- Target changes mid-search are not tracked: the result reflects the comparator answers per cycle, as sampled.
- No X on outputs after the first reset edge.

Decomposition:
- Package sar_search_pkg:
  - state enum typedef (IDLE, TRIAL, DONE)
  - localparam for MSB mask computed from DATA_WIDTH via function
- Single-file FSM; no internal sub-module.
- Optional top sar_search_loop instantiates the controller plus the team's combinational greater-or-equal comparator; the bench uses this closed loop.

Test Plan:
- Reset, then start_i with target=1234 (DATA_WIDTH=13) -> trial_o sequence 4096, 2048, 1024, 1536, 1280, 1152, 1216, 1248, 1232, 1240, 1236, 1234, 1235; done_o at T+14; result_o=1234; busy_o high T+1..T+13.
- Targets 0 and 8191 -> result_o 0 (all cmp_ge_i=0) and 8191 (all cmp_ge_i=1); done_o exactly 14 cycles after start.
- start_i pulsed at T+5 during a search for target=4096 -> ignored; result 4096; single done_o pulse.
- start_i held high continuously -> searches back-to-back; done_o every 14 cycles; second search uses a new target, e.g. 777 -> result 777.
- rst_i asserted at T+7 of a search for 5000 -> next cycle IDLE, trial_o=0, busy_o=0, result_o=0, no done_o; fresh start then yields 5000.
- Random sweep of 1000 targets plus exhaustive at DATA_WIDTH=4 -> result_o == target on every done_o.
